sha256_round_ctrl: RTL and testbench

Control FSM for the SHA-256 compression datapath. It accepts one 512-bit message block per handshake and sequences the 32-bit register bank and round logic. It generates the load enables (the `start` inputs of the working and hash registers), the round index, and the message-schedule select. It then runs 64 rounds and either feeds back into the next block or presents the final digest through a valid/ready handshake.

---
 rtl/sha256_round_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
// Control FSM for the SHA-256 compression datapath. One 512-bit block is
// accepted per blk_valid/blk_ready handshake. The block is then loaded into
// the working registers, run for ROUNDS rounds, and folded into H0..H7. If
// the block was flagged as the last of its message, the digest is presented
// through digest_valid/digest_ready.
//
// Configuration macro: SHA256_ABORT_EN
//   When defined, adds an `abort` input that returns the FSM to IDLE from any
//   busy state.
//
// Ports
//   CLK           in   system clock, rising edge
//   RST           in   synchronous active-high reset
//   blk_valid     in   message block available on the datapath input
//   blk_ready     out  controller can accept a block (IDLE)
//   first_blk     in   block is first of a message (sampled at handshake)
//   last_blk      in   block is last of a message (sampled at handshake)
//   hash_init     out  load the IV into H0..H7
//   wk_load       out  load working registers A..H from H0..H7
//   round_en      out  advance the working registers by one round
//   msg_sel       out  1 = W from message word, 0 = W from schedule
//   sched_en      out  advance the message-schedule shift register
//   round_idx     out  current round number / K-ROM address
//   hash_upd      out  H <= H + working register
//   busy          out  high in every state except IDLE
//   digest_valid  out  H0..H7 holds the final digest
//   abort         in   (SHA256_ABORT_EN only) return to IDLE
//   digest_ready  in   consumer accepts the digest

module sha256_round_ctrl #(
    parameter int ROUNDS    = 64,
    parameter int MSG_WORDS = 16,
    parameter int IDX_W     = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic             first_blk,
    input  logic             last_blk,
    output logic             hash_init,
    output logic             wk_load,
    output logic             round_en,
    output logic             msg_sel,
    output logic             sched_en,
    output logic [IDX_W-1:0] round_idx,
    output logic             hash_upd,
    output logic             busy,
    output logic             digest_valid,
`ifdef SHA256_ABORT_EN
    input  logic             abort,
`endif
    input  logic             digest_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idxNext;
    logic             r_first;
    logic             r_last;
    logic             w_accept;
    logic             w_abortHit;

    // State register, round counter and the first/last flags captured at the
    // block handshake. Reset wins over everything, including abort.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idxNext;
            if (w_abortHit) begin
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_accept) begin
                r_first <= first_blk;
                r_last  <= last_blk;
            end
        end
    end

    // Next-state and next-counter logic. The round counter runs only in
    // ROUND and is cleared on the final round so it never shows a wrap.
    always_comb begin
        w_next     = r_state;
        w_idxNext  = r_idx;
        w_accept   = 1'b0;
        w_abortHit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (blk_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next    = S_ROUND;
                w_idxNext = '0;
            end
            S_ROUND: begin
                if (r_idx == LAST_IDX) begin
                    w_next    = S_FINAL;
                    w_idxNext = '0;
                end else begin
                    w_idxNext = r_idx + IDX_W'(1);
                end
            end
            S_FINAL: begin
                w_next = r_last ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (digest_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next    = S_IDLE;
                w_idxNext = '0;
            end
        endcase
`ifdef SHA256_ABORT_EN
        if (abort && (r_state != S_IDLE)) begin
            w_next     = S_IDLE;
            w_idxNext  = '0;
            w_accept   = 1'b0;
            w_abortHit = 1'b1;
        end
`endif
    end

    // Output decode from registered state, counter and flags. The only input
    // that reaches an output is abort, which must cancel hash_upd in the same
    // cycle so that H is left untouched by an aborted block.
    always_comb begin
        blk_ready    = 1'b0;
        hash_init    = 1'b0;
        wk_load      = 1'b0;
        round_en     = 1'b0;
        msg_sel      = 1'b0;
        sched_en     = 1'b0;
        hash_upd     = 1'b0;
        busy         = 1'b1;
        digest_valid = 1'b0;
        round_idx    = r_idx;
        case (r_state)
            S_IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LOAD: begin
                hash_init = r_first;
                wk_load   = 1'b1;
            end
            S_ROUND: begin
                round_en = 1'b1;
                msg_sel  = (int'(r_idx) < MSG_WORDS);
                sched_en = !(int'(r_idx) < MSG_WORDS);
            end
            S_FINAL: begin
`ifdef SHA256_ABORT_EN
                hash_upd = !abort;
`else
                hash_upd = 1'b1;
`endif
            end
            S_DONE: begin
                digest_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Testbench for sha256_round_ctrl. A position-in-block model predicts every
// output each cycle; directed tests pin pulse counts and latencies with
// hand-computed constants.

module tb_sha256_round_ctrl;

    localparam int ROUNDS    = 64;
    localparam int MSG_WORDS = 16;
    localparam int IDX_W     = 6;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             blk_valid = 1'b0;
    logic             first_blk = 1'b0;
    logic             last_blk = 1'b0;
    logic             digest_ready = 1'b0;
    logic             blk_ready;
    logic             hash_init;
    logic             wk_load;
    logic             round_en;
    logic             msg_sel;
    logic             sched_en;
    logic [IDX_W-1:0] round_idx;
    logic             hash_upd;
    logic             busy;
    logic             digest_valid;
    logic             abortIn;
`ifdef SHA256_ABORT_EN
    logic             abort = 1'b0;
    assign abortIn = abort;
`else
    assign abortIn = 1'b0;
`endif

    sha256_round_ctrl #(
        .ROUNDS(ROUNDS),
        .MSG_WORDS(MSG_WORDS),
        .IDX_W(IDX_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .first_blk(first_blk),
        .last_blk(last_blk),
        .hash_init(hash_init),
        .wk_load(wk_load),
        .round_en(round_en),
        .msg_sel(msg_sel),
        .sched_en(sched_en),
        .round_idx(round_idx),
        .hash_upd(hash_upd),
        .busy(busy),
        .digest_valid(digest_valid),
`ifdef SHA256_ABORT_EN
        .abort(abort),
`endif
        .digest_ready(digest_ready)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmpEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: position within the current block. -1 = idle, 0 = load,
    // 1..ROUNDS = rounds, ROUNDS+1 = final, ROUNDS+2 = waiting on the consumer.
    int mPos = -1;
    bit mFirst = 1'b0;
    bit mLast = 1'b0;

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            mPos = -1;
            mFirst = 1'b0;
            mLast = 1'b0;
        end else if (abortIn && mPos != -1) begin
            mPos = -1;
            mFirst = 1'b0;
            mLast = 1'b0;
        end else if (mPos == -1) begin
            if (blk_valid) begin
                mFirst = first_blk;
                mLast = last_blk;
                mPos = 0;
            end
        end else if (mPos <= ROUNDS) begin
            mPos++;
        end else if (mPos == ROUNDS + 1) begin
            mPos = mLast ? ROUNDS + 2 : -1;
        end else if (digest_ready) begin
            mPos = -1;
        end
    end

    function automatic logic [14:0] expectedOutputs(input int pos, input bit first,
                                                    input bit abortNow);
        bit inRound;
        bit msg;
        int idx;
        inRound = (pos >= 1) && (pos <= ROUNDS);
        idx = inRound ? pos - 1 : 0;
        msg = inRound && (idx < MSG_WORDS);
        return {pos == -1, (pos == 0) && first, pos == 0, inRound, msg,
                inRound && !msg, (pos == ROUNDS + 1) && !abortNow, pos != -1,
                pos == ROUNDS + 2, IDX_W'(idx)};
    endfunction

    // Compare every output against the model on each falling edge.
    always @(negedge CLK) begin
        if (cmpEn) begin
            checkOutput("outputs",
                {17'b0, blk_ready, hash_init, wk_load, round_en, msg_sel, sched_en,
                 hash_upd, busy, digest_valid, round_idx},
                {17'b0, expectedOutputs(mPos, mFirst, abortIn)});
        end
    end

    // Event counters used by the directed tests.
    int hashInitCnt, roundEnCnt, msgSelCnt, schedEnCnt, dvCnt, seqIdx;
    int wkLoadQ[$];
    int hashUpdQ[$];
    int dvQ[$];

    always @(negedge CLK) begin
        if (cmpEn) begin
            if (hash_init) hashInitCnt++;
            if (wk_load) begin
                wkLoadQ.push_back(cyc);
                seqIdx = 0;
            end
            if (round_en) begin
                checkOutput("round_idx_seq", 32'(round_idx), 32'(seqIdx));
                seqIdx++;
                roundEnCnt++;
            end
            if (msg_sel) msgSelCnt++;
            if (sched_en) schedEnCnt++;
            if (hash_upd) hashUpdQ.push_back(cyc);
            if (digest_valid) begin
                dvCnt++;
                dvQ.push_back(cyc);
            end
        end
    end

    task automatic clearCounters();
        hashInitCnt = 0;
        roundEnCnt = 0;
        msgSelCnt = 0;
        schedEnCnt = 0;
        dvCnt = 0;
        wkLoadQ.delete();
        hashUpdQ.delete();
        dvQ.delete();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit valid, input bit first, input bit last,
                                 input bit dready);
        blk_valid = valid;
        first_blk = first;
        last_blk = last;
        digest_ready = dready;
    endtask

    function automatic bit sigSel(input int sel);
        case (sel)
            0: return wk_load;
            1: return digest_valid;
            2: return round_en && (round_idx == IDX_W'(30));
            default: return hash_upd;
        endcase
    endfunction

    task automatic waitFor(input int sel, input string name, input int budget);
        int n = 0;
        while (!sigSel(sel) && n < budget) begin
            tick();
            n++;
        end
        if (!sigSel(sel)) checkOutput({"timeout_", name}, 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    int hs;

    initial begin
        // Reset, then idle
        applyStimulus(0, 0, 0, 0);
        RST = 1'b1;
        tick();
        cmpEn = 1'b1;
        tick();
        RST = 1'b0;
        repeat (5) tick();
        checkOutput("idle_blk_ready", 32'(blk_ready), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_round_idx", 32'(round_idx), 32'd0);

        // Single block message, consumer always ready
        $display("[TB] single block");
        clearCounters();
        applyStimulus(1, 1, 1, 1);
        tick();
        hs = cyc;
        applyStimulus(0, 0, 0, 1);
        checkOutput("load_wk_load", 32'(wk_load), 32'd1);
        checkOutput("load_hash_init", 32'(hash_init), 32'd1);
        repeat (70) tick();
        checkOutput("single_round_en_cnt", 32'(roundEnCnt), 32'd64);
        checkOutput("single_msg_sel_cnt", 32'(msgSelCnt), 32'd16);
        checkOutput("single_sched_en_cnt", 32'(schedEnCnt), 32'd48);
        checkOutput("single_hash_init_cnt", 32'(hashInitCnt), 32'd1);
        checkOutput("single_hash_upd_cnt", 32'(hashUpdQ.size()), 32'd1);
        if (hashUpdQ.size() > 0)
            checkOutput("single_hash_upd_lat", 32'(hashUpdQ[0] - hs), 32'd65);
        checkOutput("single_dv_cnt", 32'(dvCnt), 32'd1);
        if (dvQ.size() > 0)
            checkOutput("single_dv_lat", 32'(dvQ[0] - hs), 32'd66);
        checkOutput("single_end_busy", 32'(busy), 32'd0);

        // Two-block message, second block offered early
        $display("[TB] two blocks");
        clearCounters();
        applyStimulus(1, 1, 0, 1);
        tick();
        hs = cyc;
        applyStimulus(1, 0, 1, 1);
        tick();
        waitFor(0, "second_load", 100);
        applyStimulus(0, 0, 0, 1);
        checkOutput("second_load_hash_init", 32'(hash_init), 32'd0);
        repeat (75) tick();
        checkOutput("two_wk_load_cnt", 32'(wkLoadQ.size()), 32'd2);
        if (wkLoadQ.size() >= 2)
            checkOutput("two_block_spacing", 32'(wkLoadQ[1] - wkLoadQ[0]), 32'd67);
        checkOutput("two_hash_init_cnt", 32'(hashInitCnt), 32'd1);
        checkOutput("two_hash_upd_cnt", 32'(hashUpdQ.size()), 32'd2);
        checkOutput("two_dv_cnt", 32'(dvCnt), 32'd1);
        if (dvQ.size() > 0)
            checkOutput("two_dv_lat", 32'(dvQ[0] - hs), 32'd133);

        // Consumer stalls in DONE while new blocks are offered
        $display("[TB] digest stall");
        clearCounters();
        applyStimulus(1, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        waitFor(1, "digest_valid", 100);
        repeat (10) begin
            applyStimulus(1, 0, 0, 0);
            tick();
            checkOutput("stall_dv", 32'(digest_valid), 32'd1);
            checkOutput("stall_blk_ready", 32'(blk_ready), 32'd0);
        end
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("release_dv", 32'(digest_valid), 32'd0);
        checkOutput("release_blk_ready", 32'(blk_ready), 32'd1);
        checkOutput("stall_wk_load_cnt", 32'(wkLoadQ.size()), 32'd1);

        // Reset in the middle of the rounds
        $display("[TB] reset mid-round");
        clearCounters();
        applyStimulus(1, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        waitFor(2, "round_30", 100);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("rst_blk_ready", 32'(blk_ready), 32'd1);
        checkOutput("rst_round_idx", 32'(round_idx), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        repeat (70) tick();
        checkOutput("rst_no_hash_upd", 32'(hashUpdQ.size()), 32'd0);
        checkOutput("rst_no_dv", 32'(dvCnt), 32'd0);
        applyStimulus(1, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        repeat (70) tick();
        checkOutput("after_rst_hash_upd", 32'(hashUpdQ.size()), 32'd1);
        checkOutput("after_rst_dv", 32'(dvCnt), 32'd1);
        checkOutput("after_rst_round_en_cnt", 32'(roundEnCnt), 32'd95);

`ifdef SHA256_ABORT_EN
        // Abort on the FINAL cycle
        $display("[TB] abort in final");
        clearCounters();
        applyStimulus(1, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        waitFor(3, "final", 100);
        abort = 1'b1;
        #1;
        checkOutput("abort_hash_upd", 32'(hash_upd), 32'd0);
        tick();
        abort = 1'b0;
        checkOutput("abort_blk_ready", 32'(blk_ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        checkOutput("abort_no_hash_upd", 32'(hashUpdQ.size()), 32'd0);
        checkOutput("abort_no_dv", 32'(dvCnt), 32'd0);
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
